// File: rtl/frame_strobe_writer_pkg.sv
// Shared definitions for the column frame-strobe writer: FSM encoding and
// header field layout.
package frame_strobe_writer_pkg;

  localparam int unsigned COL_LSB = 16;
  localparam int unsigned IDX_LSB = 0;
  localparam int unsigned IDX_W   = 5;

  localparam logic [2:0] ST_HDR    = 3'd0;
  localparam logic [2:0] ST_DATA   = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef enum logic [2:0] {
    HDR    = ST_HDR,
    DATA   = ST_DATA,
    SETUP  = ST_SETUP,
    STROBE = ST_STROBE,
    HOLD   = ST_HOLD
  } state_e;

  function automatic logic hdr_is_bad(input int unsigned col, input int unsigned idx,
                                      input int unsigned ncols, input int unsigned nframes);
    return (col >= ncols) || (idx >= nframes);
  endfunction

endpackage

// File: rtl/frame_strobe_writer_if.sv
// Word-stream handshake into the frame strobe writer.
interface frame_strobe_writer_if #(
  parameter int unsigned DW = 32
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/frame_strobe_writer_bank.sv
// Per-row FrameData storage: NumRows words, one row written per enabled cycle.
module frame_data_reg_bank #(
  parameter int unsigned NumRows = 16,
  parameter int unsigned RowBits = 32,
  parameter int unsigned RowW    = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_we,
  input  logic [RowW-1:0]            i_row,
  input  logic [RowBits-1:0]         i_wdata,
  output logic [RowBits*NumRows-1:0] o_data
);

  logic [RowBits-1:0] r_rows [NumRows];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NumRows; i++) r_rows[i] <= '0;
    end else if (i_we) begin
      r_rows[i_row] <= i_wdata;
    end
  end

  for (genvar g = 0; g < NumRows; g++) begin : g_flat
    assign o_data[g*RowBits +: RowBits] = r_rows[g];
  end

endmodule

// File: rtl/frame_strobe_writer.sv
// Loads one frame of row data from a word stream, then strobes it into the
// selected column/frame with setup and hold around FrameStrobe.
module frame_strobe_writer
  import frame_strobe_writer_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol  = 20,
  parameter int unsigned FrameSelectWidth = 5,
  parameter int unsigned NumCols          = 8,
  parameter int unsigned NumRows          = 16,
  parameter int unsigned FrameBitsPerRow  = 32,
  parameter int unsigned StrobeCycles     = 2
) (
  input  logic                                 CLK,
  input  logic                                 resetn,
  frame_strobe_writer_if.slave                 s,
  output logic [FrameBitsPerRow*NumRows-1:0]   FrameData,
  output logic [FrameSelectWidth-1:0]          FrameSelect,
  output logic                                 FrameStrobe,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe_I,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 err,
  input  logic                                 err_clr
);

  localparam int unsigned ROW_W  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned SCNT_W = $clog2(StrobeCycles + 1);

  state_e                       r_state, w_state_nxt;
  logic [ROW_W-1:0]             r_row;
  logic [SCNT_W-1:0]            r_scnt;
  logic [FrameSelectWidth-1:0]  r_col, r_sel;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_bad;
  logic                         r_s_ready, r_busy, r_strobe, r_done, r_err;
  logic [MaxFramesPerCol-1:0]   r_stb_i;

  logic                         w_acc, w_last_row, w_strobe_last, w_hdr_bad, w_we;
  logic [FrameSelectWidth-1:0]  w_hdr_col;
  logic [IDX_W-1:0]             w_hdr_idx;
  logic [MaxFramesPerCol-1:0]   w_onehot;

  assign w_acc         = s.s_valid & r_s_ready;
  assign w_hdr_col     = s.s_data[COL_LSB +: FrameSelectWidth];
  assign w_hdr_idx     = s.s_data[IDX_LSB +: IDX_W];
  assign w_hdr_bad     = hdr_is_bad(32'(w_hdr_col), 32'(w_hdr_idx), NumCols, MaxFramesPerCol);
  assign w_last_row    = (r_row == ROW_W'(NumRows - 1));
  assign w_strobe_last = (r_scnt == SCNT_W'(StrobeCycles));
  assign w_onehot      = MaxFramesPerCol'(1) << r_idx;
  assign w_we          = (r_state == DATA) && w_acc && !r_bad;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HDR:     if (w_acc) w_state_nxt = DATA;
      DATA:    if (w_acc && w_last_row) w_state_nxt = r_bad ? HDR : SETUP;
      SETUP:   w_state_nxt = STROBE;
      STROBE:  if (w_strobe_last) w_state_nxt = HOLD;
      HOLD:    w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      r_state   <= HDR;
      r_row     <= '0;
      r_scnt    <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_bad     <= 1'b0;
      r_sel     <= '0;
      r_stb_i   <= '0;
      r_s_ready <= 1'b1;
      r_busy    <= 1'b0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt == HDR) || (w_state_nxt == DATA);
      r_busy    <= (w_state_nxt != HDR);
      r_strobe  <= (w_state_nxt == STROBE);
      r_done    <= (w_state_nxt == HOLD);

      if (r_state == HDR && w_acc) begin
        r_col <= w_hdr_col;
        r_idx <= w_hdr_idx;
        r_bad <= w_hdr_bad;
        r_row <= '0;
      end else if (r_state == DATA && w_acc && !w_last_row) begin
        r_row <= r_row + 1'b1;
      end

      if (r_state == SETUP) begin
        r_scnt <= SCNT_W'(1);
      end else if (r_state == STROBE && !w_strobe_last) begin
        r_scnt <= r_scnt + 1'b1;
      end

      if (w_state_nxt == SETUP) begin
        r_sel   <= r_col;
        r_stb_i <= w_onehot;
      end else if (w_state_nxt == HDR) begin
        r_stb_i <= '0;
      end

      if (r_state == DATA && w_acc && w_last_row && r_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  frame_data_reg_bank #(
    .NumRows (NumRows),
    .RowBits (FrameBitsPerRow),
    .RowW    (ROW_W)
  ) u_bank (
    .i_clk   (CLK),
    .i_rst_n (resetn),
    .i_we    (w_we),
    .i_row   (r_row),
    .i_wdata (s.s_data),
    .o_data  (FrameData)
  );

  assign s.s_ready     = r_s_ready;
  assign FrameSelect   = r_sel;
  assign FrameStrobe   = r_strobe;
  assign FrameStrobe_I = r_stb_i;
  assign busy          = r_busy;
  assign frame_done    = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_frame_strobe_writer.sv
// Directed + randomized bench for frame_strobe_writer against a frame-level model.
module tb_frame_strobe_writer;

  localparam int NR = 16;
  localparam int NC = 8;
  localparam int MF = 20;

  logic         CLK = 1'b0;
  logic         resetn;
  logic         err_clr;
  logic [511:0] FrameData;
  logic [4:0]   FrameSelect;
  logic         FrameStrobe;
  logic [19:0]  FrameStrobe_I;
  logic         busy, frame_done, err;

  frame_strobe_writer_if #(.DW(32)) s_if ();

  frame_strobe_writer #(
    .MaxFramesPerCol  (20),
    .FrameSelectWidth (5),
    .NumCols          (8),
    .NumRows          (16),
    .FrameBitsPerRow  (32),
    .StrobeCycles     (2)
  ) dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .s             (s_if),
    .FrameData     (FrameData),
    .FrameSelect   (FrameSelect),
    .FrameStrobe   (FrameStrobe),
    .FrameStrobe_I (FrameStrobe_I),
    .busy          (busy),
    .frame_done    (frame_done),
    .err           (err),
    .err_clr       (err_clr)
  );

  always #5 CLK = ~CLK;

  int unsigned  n_pass  = 0;
  int unsigned  n_total = 0;
  logic [31:0]  m_fd [NR];
  logic         m_err;
  logic [4:0]   m_sel;

  function automatic logic [511:0] m_flat();
    logic [511:0] v;
    for (int r = 0; r < NR; r++) v[r*32 +: 32] = m_fd[r];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit gaps);
    int unsigned t;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        s_if.s_valid = 1'b0;
        tick();
        chk("idle_no_strobe", FrameStrobe, 0);
      end
    end
    s_if.s_valid = 1'b1;
    s_if.s_data  = w;
    t = 0;
    while (s_if.s_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (t == 50) chk("ready_timeout", s_if.s_ready, 1);
    tick();
    s_if.s_valid = 1'b0;
    s_if.s_data  = $urandom;
  endtask

  task automatic run_frame(input int col, input int idx, input bit gaps,
                           input bit clr_on_last, input bit fixed_data, input bit skip_hdr);
    logic [31:0] hdr, w;
    logic [19:0] oh;
    bit          bad;
    bad = (col >= NC) || (idx >= MF);
    if (!skip_hdr) begin
      hdr = ($urandom & 32'hFFE0_FFE0) | (32'(col) << 16) | 32'(idx);
      send(hdr, 1'b0);
      chk("busy_after_hdr", busy, 1);
    end
    for (int r = 0; r < NR; r++) begin
      w = fixed_data ? (32'hA000_0000 + 32'(r)) : $urandom;
      if (r == NR - 1 && clr_on_last) err_clr = 1'b1;
      send(w, gaps);
      err_clr = 1'b0;
      if (!bad) m_fd[r] = w;
      if (r < NR - 1) chk("no_early_setup", s_if.s_ready, 1);
    end
    if (bad) begin
      m_err = 1'b1;
      chk("bad_err", err, m_err);
      chk("bad_ready", s_if.s_ready, 1);
      chk("bad_busy", busy, 0);
      chk("bad_no_strobe", FrameStrobe, 0);
      chk("bad_no_sel_i", FrameStrobe_I, 0);
      chk("bad_fd_unchanged", FrameData, m_flat());
    end else begin
      oh    = 20'(1) << idx;
      m_sel = 5'(col);
      chk("setup_ready", s_if.s_ready, 0);
      chk("setup_strobe", FrameStrobe, 0);
      chk("setup_sel", FrameSelect, m_sel);
      chk("setup_onehot", FrameStrobe_I, oh);
      chk("setup_fd", FrameData, m_flat());
      for (int k = 0; k < 2; k++) begin
        tick();
        chk("strobe_hi", FrameStrobe, 1);
        chk("strobe_onehot", FrameStrobe_I, oh);
        chk("strobe_sel", FrameSelect, m_sel);
        chk("strobe_ready", s_if.s_ready, 0);
        chk("strobe_done", frame_done, 0);
        chk("strobe_fd", FrameData, m_flat());
      end
      tick();
      chk("hold_strobe", FrameStrobe, 0);
      chk("hold_done", frame_done, 1);
      chk("hold_onehot", FrameStrobe_I, oh);
      chk("hold_sel", FrameSelect, m_sel);
      chk("hold_ready", s_if.s_ready, 0);
      chk("hold_fd", FrameData, m_flat());
      tick();
      chk("idle_done", frame_done, 0);
      chk("idle_onehot", FrameStrobe_I, 0);
      chk("idle_busy", busy, 0);
      chk("idle_ready", s_if.s_ready, 1);
      chk("idle_sel_held", FrameSelect, m_sel);
      chk("idle_err", err, m_err);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err   = 1'b0;
    chk("err_cleared", err, m_err);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hdr;
    int          c, i;
    resetn       = 1'b0;
    err_clr      = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    m_err        = 1'b0;
    m_sel        = '0;
    for (int r = 0; r < NR; r++) m_fd[r] = '0;

    #12;
    chk("rst_ready", s_if.s_ready, 1);
    chk("rst_fd", FrameData, 0);
    chk("rst_sel", FrameSelect, 0);
    chk("rst_strobe", FrameStrobe, 0);
    chk("rst_onehot", FrameStrobe_I, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err, 0);
    @(negedge CLK);
    resetn = 1'b1;
    tick();

    // Basic frame with known row pattern
    run_frame(3, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    // Frame index out of range, then clear
    run_frame(5, 20, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clr();
    // Column out of range with clear held in the setting cycle
    run_frame(8, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(1, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_clr();

    // Randomized frames with handshake gaps, some with bad headers
    for (int n = 0; n < 8; n++) begin
      c = $urandom_range(0, 9);
      i = $urandom_range(0, 22);
      run_frame(c, i, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    pulse_clr();

    // Reset during the first strobe cycle
    hdr = (32'(2) << 16) | 32'(11);
    send(hdr, 1'b0);
    for (int r = 0; r < NR; r++) send($urandom, 1'b0);
    tick();
    chk("pre_rst_strobe", FrameStrobe, 1);
    resetn = 1'b0;
    #1;
    for (int r = 0; r < NR; r++) m_fd[r] = '0;
    m_err = 1'b0;
    m_sel = '0;
    chk("arst_strobe", FrameStrobe, 0);
    chk("arst_onehot", FrameStrobe_I, 0);
    chk("arst_fd", FrameData, m_flat());
    chk("arst_sel", FrameSelect, m_sel);
    chk("arst_ready", s_if.s_ready, 1);
    chk("arst_busy", busy, 0);
    #3;
    resetn       = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = (32'(6) << 16) | 32'(13);
    chk("post_rst_ready", s_if.s_ready, 1);
    tick();
    s_if.s_valid = 1'b0;
    chk("post_rst_hdr_taken", busy, 1);
    run_frame(6, 13, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back extremes
    run_frame(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(7, 19, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
